// File: rtl/fwvip_wb_mem_pkg.sv
// Shared types and sizing helpers for the Wishbone memory responder.
package fwvip_wb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned MODE_CLASSIC   = 0;
  localparam int unsigned MODE_PIPELINED = 1;

  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fwvip_wb_mem_responder_if.sv
// Wishbone bus bundle between a bus master and the memory responder.
interface fwvip_wb_mem_responder_if
  import fwvip_wb_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]                 adr;
  logic                                  cyc;
  logic                                  stb;
  logic                                  we;
  logic [lane_count(DATA_WIDTH)-1:0]     sel;
  logic [DATA_WIDTH-1:0]                 dat_w;
  logic [DATA_WIDTH-1:0]                 dat_r;
  logic                                  ack;
  logic                                  err;
  logic                                  stall;

  modport master (
    output adr, cyc, stb, we, sel, dat_w,
    input  dat_r, ack, err, stall
  );

  modport slave (
    input  adr, cyc, stb, we, sel, dat_w,
    output dat_r, ack, err, stall
  );
endinterface

// File: rtl/fwvip_wb_mem_array.sv
// Single-port word RAM with per-byte write enables and registered read data.
module fwvip_wb_mem_array
  import fwvip_wb_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                              clock,
  input  logic [idx_width(DEPTH)-1:0]       addr_i,
  input  logic                              we_i,
  input  logic [lane_count(DATA_WIDTH)-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  input  logic                              re_i,
  output logic [DATA_WIDTH-1:0]             rdata_o
);
  localparam int unsigned LANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fwvip_wb_mem_responder.sv
// Wishbone memory responder: address decode, wait-state FSM, ack/err and stall generation.
module fwvip_wb_mem_responder
  import fwvip_wb_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           PIPELINED  = MODE_CLASSIC
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              wait_states,
  fwvip_wb_mem_responder_if.slave bus
);
  localparam int unsigned LANES = lane_count(DATA_WIDTH);
  localparam int unsigned IDXW  = idx_width(DEPTH);
  localparam int unsigned LSB   = (LANES > 1) ? $clog2(LANES) : 0;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic            inr_q;
  logic [IDXW-1:0] idx_q;
  logic            ack_q;
  logic            err_q;
  logic            rd_valid_q;

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word;
  logic [IDXW-1:0]       dec_idx;
  logic                  dec_inr;
  logic                  can_accept;
  logic                  accept;
  logic                  ws_zero;
  logic                  wait_done;
  logic                  mem_we;
  logic                  mem_re;
  logic [IDXW-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // DEPTH is a power of two, so idx < DEPTH reduces to the bits above IDXW being zero.
  always_comb begin
    off     = bus.adr - BASE_ADDR;
    word    = off >> LSB;
    dec_idx = word[IDXW-1:0];
    dec_inr = (bus.adr >= BASE_ADDR) && ((word >> IDXW) == '0);
  end

  assign can_accept = reset && ((state_q == IDLE) || ((PIPELINED != 0) && (state_q == RESP)));
  // The accept-cycle stall term is advisory only; gating accept on it would form a loop.
  assign accept     = can_accept && bus.cyc && bus.stb;
  assign ws_zero    = (wait_states == '0);
  assign wait_done  = (state_q == WAIT) && bus.cyc && (cnt_q == 4'd1);

  assign mem_we   = accept && dec_inr && bus.we;
  assign mem_re   = (accept && ws_zero && dec_inr && !bus.we) || (wait_done && inr_q && !we_q);
  assign mem_addr = accept ? dec_idx : idx_q;

  fwvip_wb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clock   (clock),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .be_i    (bus.sel),
    .wdata_i (bus.dat_w),
    .re_i    (mem_re),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      inr_q      <= 1'b0;
      idx_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      if (accept) begin
        we_q  <= bus.we;
        idx_q <= dec_idx;
        inr_q <= dec_inr;
        cnt_q <= wait_states;
        if (ws_zero) begin
          state_q    <= RESP;
          ack_q      <= dec_inr;
          err_q      <= !dec_inr;
          rd_valid_q <= dec_inr && !bus.we;
        end else begin
          state_q <= WAIT;
        end
      end else begin
        case (state_q)
          WAIT: begin
            if (!bus.cyc) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (wait_done) begin
              state_q    <= RESP;
              cnt_q      <= '0;
              ack_q      <= inr_q;
              err_q      <= !inr_q;
              rd_valid_q <= inr_q && !we_q;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          RESP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.dat_r = rd_valid_q ? mem_rdata : '0;
  assign bus.stall = (PIPELINED != 0) && reset && ((state_q == WAIT) || (accept && !ws_zero));

endmodule

// File: tb/tb_fwvip_wb_mem_responder.sv
// Directed bench: one classic and one pipelined responder sharing clock and reset.
module tb_fwvip_wb_mem_responder;
  import fwvip_wb_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ws_c;
  logic [3:0] ws_p;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  fwvip_wb_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_c ();
  fwvip_wb_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_p ();

  fwvip_wb_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h0), .PIPELINED(0)
  ) dut_c (
    .clock(clk), .reset(rst_n), .wait_states(ws_c), .bus(bus_c.slave)
  );

  fwvip_wb_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h0), .PIPELINED(1)
  ) dut_p (
    .clock(clk), .reset(rst_n), .wait_states(ws_p), .bus(bus_p.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_c(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    bus_c.cyc = 1'b1; bus_c.stb = 1'b1; bus_c.we = we;
    bus_c.adr = adr;  bus_c.sel = sel;  bus_c.dat_w = dat;
  endtask

  task automatic idle_c();
    bus_c.cyc = 1'b0; bus_c.stb = 1'b0; bus_c.we = 1'b0;
  endtask

  task automatic req_p(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus_p.cyc = 1'b1; bus_p.stb = 1'b1; bus_p.we = we;
    bus_p.adr = adr;  bus_p.sel = 4'hF; bus_p.dat_w = dat;
  endtask

  task automatic idle_p();
    bus_p.cyc = 1'b0; bus_p.stb = 1'b0; bus_p.we = 1'b0;
  endtask

  // Classic transfer; lat counts edges from the accept edge to the response (0 = no response).
  task automatic xfer_c(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wdat, input logic [3:0] ws,
                        output int lat, output logic ack, output logic err,
                        output logic [31:0] rd, output logic tail);
    ws_c = ws;
    req_c(we, adr, sel, wdat);
    lat = 0; ack = 1'b0; err = 1'b0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus_c.ack || bus_c.err) begin
        lat = k; ack = bus_c.ack; err = bus_c.err; rd = bus_c.dat_r;
        break;
      end
    end
    idle_c();
    tick();
    tail = bus_c.ack || bus_c.err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ws_c = '0; ws_p = '0;
    bus_c.adr = '0; bus_c.sel = '0; bus_c.dat_w = '0; idle_c();
    bus_p.adr = '0; bus_p.sel = '0; bus_p.dat_w = '0; idle_p();
    #1;
    n_cmp++; if (bus_c.ack !== 1'b0) begin n_bad++; $display("FAIL rst_c_ack got %b want 0", bus_c.ack); end
    n_cmp++; if (bus_c.err !== 1'b0) begin n_bad++; $display("FAIL rst_c_err got %b want 0", bus_c.err); end
    n_cmp++; if (bus_c.dat_r !== 32'h0) begin n_bad++; $display("FAIL rst_c_dat got %h want 0", bus_c.dat_r); end
    n_cmp++; if (bus_p.stall !== 1'b0) begin n_bad++; $display("FAIL rst_p_stall got %b want 0", bus_p.stall); end
    n_cmp++; if (bus_p.ack !== 1'b0) begin n_bad++; $display("FAIL rst_p_ack got %b want 0", bus_p.ack); end
    n_cmp++; if (dut_p.state_q !== IDLE) begin n_bad++; $display("FAIL rst_p_state got %0d want IDLE", dut_p.state_q); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_classic();
    int lat; logic ack, err, tail; logic [31:0] rd;
    xfer_c(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd0, lat, ack, err, rd, tail);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL cl_wr_lat got %0d want 1", lat); end
    n_cmp++; if (ack !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL cl_wr_resp got ack=%b err=%b want ack=1 err=0", ack, err); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL cl_wr_dat got %h want 0", rd); end
    n_cmp++; if (tail !== 1'b0) begin n_bad++; $display("FAIL cl_wr_tail got %b want 0", tail); end
    xfer_c(1'b0, 32'h10, 4'hF, 32'h0, 4'd0, lat, ack, err, rd, tail);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL cl_rd_lat got %0d want 1", lat); end
    n_cmp++; if (ack !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL cl_rd_resp got ack=%b err=%b want ack=1 err=0", ack, err); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cl_rd_dat got %h want deadbeef", rd); end
    n_cmp++; if (tail !== 1'b0) begin n_bad++; $display("FAIL cl_rd_tail got %b want 0", tail); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic ack, err, tail; logic [31:0] rd;
    xfer_c(1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 4'd0, lat, ack, err, rd, tail);
    xfer_c(1'b1, 32'h20, 4'h5, 32'h11223344, 4'd0, lat, ack, err, rd, tail);
    xfer_c(1'b0, 32'h20, 4'hF, 32'h0, 4'd0, lat, ack, err, rd, tail);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL lanes_ack got %b want 1", ack); end
    n_cmp++; if (rd !== 32'hFF22FF44) begin n_bad++; $display("FAIL lanes_dat got %h want ff22ff44", rd); end
  endtask

  task automatic test_wait_states_classic();
    int lat; logic ack, err, tail; logic [31:0] rd;
    xfer_c(1'b0, 32'h10, 4'hF, 32'h0, 4'd3, lat, ack, err, rd, tail);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ws3_lat got %0d want 4", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ws3_dat got %h want deadbeef", rd); end
    n_cmp++; if (tail !== 1'b0) begin n_bad++; $display("FAIL ws3_tail got %b want 0", tail); end
  endtask

  task automatic test_out_of_range();
    int lat; logic ack, err, tail; logic [31:0] rd;
    xfer_c(1'b1, 32'h0, 4'hF, 32'h01020304, 4'd0, lat, ack, err, rd, tail);
    xfer_c(1'b0, 32'h1000, 4'hF, 32'h0, 4'd0, lat, ack, err, rd, tail);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL oor_rd_lat got %0d want 1", lat); end
    n_cmp++; if (err !== 1'b1 || ack !== 1'b0) begin n_bad++; $display("FAIL oor_rd_resp got ack=%b err=%b want ack=0 err=1", ack, err); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_rd_dat got %h want 0", rd); end
    xfer_c(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 4'd0, lat, ack, err, rd, tail);
    n_cmp++; if (err !== 1'b1 || ack !== 1'b0) begin n_bad++; $display("FAIL oor_wr_resp got ack=%b err=%b want ack=0 err=1", ack, err); end
    xfer_c(1'b0, 32'h0, 4'hF, 32'h0, 4'd0, lat, ack, err, rd, tail);
    n_cmp++; if (rd !== 32'h01020304) begin n_bad++; $display("FAIL oor_mem0 got %h want 01020304", rd); end
    xfer_c(1'b1, 32'hFFC, 4'hF, 32'h5A5A5A5A, 4'd0, lat, ack, err, rd, tail);
    xfer_c(1'b0, 32'hFFF, 4'hF, 32'h0, 4'd0, lat, ack, err, rd, tail);
    n_cmp++; if (ack !== 1'b1 || rd !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL last_word got ack=%b dat=%h want ack=1 dat=5a5a5a5a", ack, rd); end
  endtask

  task automatic test_back_to_back();
    int ack_cnt; logic stall_seen;
    ws_p = 4'd0;
    ack_cnt = 0; stall_seen = 1'b0;
    req_p(1'b1, 32'h0, 32'hA0000000);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus_p.stall) stall_seen = 1'b1;
      tick();
      if (i < 7) req_p(1'b1, 32'((i + 1) * 4), 32'hA0000000 + 32'(i + 1));
      else idle_p();
      #1;
      if (bus_p.ack && !bus_p.err) ack_cnt++;
    end
    n_cmp++; if (ack_cnt !== 8) begin n_bad++; $display("FAIL b2b_wr_acks got %0d want 8", ack_cnt); end
    ack_cnt = 0;
    req_p(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus_p.stall) stall_seen = 1'b1;
      tick();
      if (i < 7) req_p(1'b0, 32'((i + 1) * 4), 32'h0);
      else idle_p();
      #1;
      if (bus_p.ack && !bus_p.err) ack_cnt++;
      n_cmp++;
      if (bus_p.dat_r !== 32'hA0000000 + 32'(i)) begin
        n_bad++; $display("FAIL b2b_rd_dat[%0d] got %h want %h", i, bus_p.dat_r, 32'hA0000000 + 32'(i));
      end
    end
    n_cmp++; if (ack_cnt !== 8) begin n_bad++; $display("FAIL b2b_rd_acks got %0d want 8", ack_cnt); end
    n_cmp++; if (stall_seen !== 1'b0) begin n_bad++; $display("FAIL b2b_stall got %b want 0", stall_seen); end
    tick();
    n_cmp++; if (bus_p.ack !== 1'b0) begin n_bad++; $display("FAIL b2b_tail got %b want 0", bus_p.ack); end
  endtask

  task automatic test_wait_states_pipelined();
    int stall_cnt; logic early;
    ws_p = 4'd3;
    req_p(1'b0, 32'h8, 32'h0);
    #1;
    n_cmp++; if (bus_p.stall !== 1'b1) begin n_bad++; $display("FAIL pws_accept_stall got %b want 1", bus_p.stall); end
    tick();
    bus_p.stb = 1'b0;
    stall_cnt = 0; early = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus_p.stall) stall_cnt++;
      if (bus_p.ack || bus_p.err) early = 1'b1;
      tick();
    end
    #1;
    n_cmp++; if (stall_cnt !== 3) begin n_bad++; $display("FAIL pws_stall_cycles got %0d want 3", stall_cnt); end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL pws_early_resp got %b want 0", early); end
    n_cmp++; if (bus_p.ack !== 1'b1 || bus_p.stall !== 1'b0) begin n_bad++; $display("FAIL pws_resp got ack=%b stall=%b want ack=1 stall=0", bus_p.ack, bus_p.stall); end
    n_cmp++; if (bus_p.dat_r !== 32'hA0000002) begin n_bad++; $display("FAIL pws_dat got %h want a0000002", bus_p.dat_r); end
    idle_p();
    tick();
    n_cmp++; if (bus_p.ack !== 1'b0) begin n_bad++; $display("FAIL pws_tail got %b want 0", bus_p.ack); end
  endtask

  task automatic test_abort();
    int lat; logic ack, err, tail; logic [31:0] rd; logic seen;
    ws_c = 4'd3;
    req_c(1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    idle_c();
    tick();
    n_cmp++; if (dut_c.state_q !== IDLE) begin n_bad++; $display("FAIL abort_state got %0d want IDLE", dut_c.state_q); end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus_c.ack || bus_c.err) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_resp got %b want 0", seen); end
    xfer_c(1'b0, 32'h10, 4'hF, 32'h0, 4'd0, lat, ack, err, rd, tail);
    n_cmp++; if (lat !== 1 || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL abort_recover got lat=%0d dat=%h want lat=1 dat=deadbeef", lat, rd); end
  endtask

  task automatic test_reset_mid_transfer();
    int lat; logic ack, err, tail; logic [31:0] rd;
    ws_c = 4'd0; ws_p = 4'd5;
    req_c(1'b0, 32'h10, 4'hF, 32'h0);
    req_p(1'b0, 32'h4, 32'h0);
    tick();
    idle_c();
    bus_p.stb = 1'b0;
    #1;
    n_cmp++; if (bus_c.ack !== 1'b1 || bus_p.stall !== 1'b1) begin n_bad++; $display("FAIL mid_pre got c_ack=%b p_stall=%b want 1 1", bus_c.ack, bus_p.stall); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_c.ack !== 1'b0 || bus_c.dat_r !== 32'h0) begin n_bad++; $display("FAIL mid_rst_c got ack=%b dat=%h want 0 0", bus_c.ack, bus_c.dat_r); end
    n_cmp++; if (bus_p.stall !== 1'b0 || bus_p.ack !== 1'b0 || bus_p.err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_p got stall=%b ack=%b err=%b want 0 0 0", bus_p.stall, bus_p.ack, bus_p.err); end
    idle_p();
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    n_cmp++; if (bus_p.ack !== 1'b0 || bus_p.err !== 1'b0) begin n_bad++; $display("FAIL mid_discard got ack=%b err=%b want 0 0", bus_p.ack, bus_p.err); end
    xfer_c(1'b0, 32'h10, 4'hF, 32'h0, 4'd0, lat, ack, err, rd, tail);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mid_keep_c got %h want deadbeef", rd); end
    ws_p = 4'd0;
    req_p(1'b0, 32'h4, 32'h0);
    tick();
    idle_p();
    #1;
    n_cmp++; if (bus_p.ack !== 1'b1 || bus_p.dat_r !== 32'hA0000001) begin n_bad++; $display("FAIL mid_keep_p got ack=%b dat=%h want ack=1 dat=a0000001", bus_p.ack, bus_p.dat_r); end
    tick();
  endtask

  initial begin
    test_reset();
    test_classic();
    test_byte_lanes();
    test_wait_states_classic();
    test_out_of_range();
    test_back_to_back();
    test_wait_states_pipelined();
    test_abort();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
